// File: rtl/vga_axil_regfile.sv
// rtl/vga_axil_regfile.sv - AXI4-Lite slave register file for the VGA control plane
module vga_axil_regfile #(
    parameter int                         ADDR_W   = 32,
    parameter int                         DATA_W   = 32,
    parameter int                         NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0]        RO_MASK  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_i,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFFS   = $clog2(STRB_W);

    logic                aw_full;
    logic                w_full;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [ADDR_W-1:0]   wr_idx;
    logic [ADDR_W-1:0]   rd_idx;
    logic [NUM_REGS-1:0] wr_hit;
    logic [DATA_W-1:0]   rd_val;
    logic                rd_in_range;
    logic [1:0]          wr_resp;
    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                commit;

    assign awready = !aw_full;
    assign wready  = !w_full;
    assign arready = !rvalid || rready;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign commit  = aw_full && w_full && (!bvalid || bready);

    assign wr_idx = aw_addr_q >> OFFS;
    assign rd_idx = araddr >> OFFS;

    // Read-only registers source their value from ro_i; their storage stays at zero.
    always_comb begin
        wr_hit      = '0;
        rd_val      = '0;
        rd_in_range = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = (wr_idx == ADDR_W'(i));
            if (rd_idx == ADDR_W'(i)) begin
                rd_in_range = 1'b1;
                rd_val      = RO_MASK[i] ? ro_i[i*DATA_W +: DATA_W] : regs_q[i];
            end
        end
    end

    always_comb begin
        wr_resp = 2'b00;
        if (wr_hit == '0) begin
            wr_resp = 2'b11;
        end else if ((wr_hit & RO_MASK) != '0) begin
            wr_resp = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            aw_full    <= 1'b0;
            w_full     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid     <= 1'b0;
            bresp      <= 2'b00;
            rvalid     <= 1'b0;
            rresp      <= 2'b00;
            rdata      <= '0;
            wr_pulse_o <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RO_MASK[i] ? '0 : RST_VAL[i*DATA_W +: DATA_W];
            end
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
            end else if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= awaddr;
            end

            if (commit) begin
                w_full <= 1'b0;
            end else if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end

            // A zero strobe still counts as a committed write and pulses.
            wr_pulse_o <= commit ? (wr_hit & ~RO_MASK) : '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int k = 0; k < STRB_W; k++) begin
                    if (commit && wr_hit[i] && !RO_MASK[i] && w_strb_q[k]) begin
                        regs_q[i][8*k +: 8] <= w_data_q[8*k +: 8];
                    end
                end
            end

            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= wr_resp;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end

            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_val;
                rresp  <= rd_in_range ? 2'b00 : 2'b11;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
        assign regs_o[i*DATA_W +: DATA_W] = regs_q[i];
    end
endmodule

// File: tb/tb_vga_axil_regfile.sv
// tb/tb_vga_axil_regfile.sv - scoreboard testbench for vga_axil_regfile
module tb_vga_axil_regfile;
    localparam int NR = 8;
    localparam logic [NR-1:0] RO = 8'b0001_0000;
    localparam logic [NR*32-1:0] RST = {32'h7777_0007, 32'h0, 32'h5555_0005, 32'h0,
                                        32'h0000_0280, 32'h2020_2020, 32'h1122_3344, 32'hCAFE_0000};

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic            clk = 1'b0;
    logic            arst_n;
    logic [31:0]     awaddr, wdata, araddr;
    logic            awvalid, wvalid, bready, arvalid, rready;
    logic [3:0]      wstrb;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [1:0]      bresp, rresp;
    logic [31:0]     rdata;
    logic [NR*32-1:0] regs_o, ro_i;
    logic [NR-1:0]   wr_pulse_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] b_q[$];
    r_exp_t     r_q[$];

    vga_axil_regfile #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .RO_MASK(RO), .RST_VAL(RST)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_o(regs_o), .ro_i(ro_i), .wr_pulse_o(wr_pulse_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout waiting on DUT", name);
    endtask

    function automatic logic [31:0] slice(input int i);
        return regs_o[i*32 +: 32];
    endfunction

    // Response monitor: pops the expected B/R entry on every handshake.
    always @(negedge clk) begin
        if (arst_n) begin
            if (bvalid && bready) begin
                if (b_q.size() == 0) fail("b_unexpected");
                else chk("bresp", 256'(bresp), 256'(b_q.pop_front()));
            end
            if (rvalid && rready) begin
                if (r_q.size() == 0) begin
                    fail("r_unexpected");
                end else begin
                    r_exp_t e;
                    e = r_q.pop_front();
                    chk("rdata", 256'(rdata), 256'(e.data));
                    chk("rresp", 256'(rresp), 256'(e.resp));
                end
            end
        end
    end

    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done = 0;
        bit w_done = 0;
        int t = 0;
        @(posedge clk); #1;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        while (!(aw_done && w_done)) begin
            bit aw_now, w_now;
            @(negedge clk);
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_now) begin awvalid = 1'b0; aw_done = 1; end
            if (w_now)  begin wvalid = 1'b0;  w_done = 1;  end
            t++;
            if (t > 50) begin
                fail("aw_w_handshake");
                awvalid = 1'b0; wvalid = 1'b0;
                break;
            end
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] eresp, input logic [7:0] epulse);
        b_q.push_back(eresp);
        send_aw_w(a, d, s);
        @(negedge clk); chk("pulse_pre", 256'(wr_pulse_o), 256'(0));
        @(negedge clk); chk("pulse", 256'(wr_pulse_o), 256'(epulse));
        chk("bvalid_commit", 256'(bvalid), 256'(1));
        @(negedge clk); chk("pulse_end", 256'(wr_pulse_o), 256'(0));
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] edata, input logic [1:0] eresp);
        int t = 0;
        r_q.push_back('{edata, eresp});
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        forever begin
            bit now;
            @(negedge clk);
            now = arready;
            @(posedge clk); #1;
            if (now) begin
                arvalid = 1'b0;
                chk("rvalid_latency", 256'(rvalid), 256'(1));
                break;
            end
            t++;
            if (t > 50) begin fail("ar_handshake"); arvalid = 1'b0; break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        arst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
        ro_i = {NR{32'hFFFF_FFFF}};
        ro_i[4*32 +: 32] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;

        @(negedge clk);
        chk("rst_awready", 256'(awready), 256'(1));
        chk("rst_wready", 256'(wready), 256'(1));
        chk("rst_arready", 256'(arready), 256'(1));
        chk("rst_bvalid", 256'(bvalid), 256'(0));
        chk("rst_rvalid", 256'(rvalid), 256'(0));
        chk("rst_rdata", 256'(rdata), 256'(0));
        chk("rst_pulse", 256'(wr_pulse_o), 256'(0));
        chk("rst_regs", 256'(regs_o), 256'(RST));

        axi_read(32'h0C, 32'h0000_0280, 2'b00);

        axi_write(32'h04, 32'hAABB_CCDD, 4'b0101, 2'b00, 8'b0000_0010);
        chk("strobed_reg1", 256'(slice(1)), 256'(32'h11BB_33DD));

        // W first, AW five cycles later
        @(posedge clk); #1;
        b_q.push_back(2'b00);
        wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk); chk("skew_wready_c0", 256'(wready), 256'(1));
        @(posedge clk); #1 wvalid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) begin awaddr = 32'h08; awvalid = 1'b1; end
            @(negedge clk);
            chk($sformatf("skew_wready_c%0d", c), 256'(wready), 256'(0));
            chk($sformatf("skew_bvalid_c%0d", c), 256'(bvalid), 256'(0));
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        @(negedge clk); chk("skew_bvalid_c6", 256'(bvalid), 256'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("skew_bvalid_c7", 256'(bvalid), 256'(1));
        chk("skew_pulse_c7", 256'(wr_pulse_o), 256'(8'b0000_0100));
        chk("skew_reg2", 256'(slice(2)), 256'(32'h5555_AAAA));

        axi_write(32'h10, 32'h1234_5678, 4'hF, 2'b10, 8'b0);
        chk("ro_reg4_storage", 256'(slice(4)), 256'(0));
        axi_write(32'h24, 32'h1234_5678, 4'hF, 2'b11, 8'b0);
        chk("decerr_regs", 256'(regs_o[NR*32-1:3*32]), 256'(RST[NR*32-1:3*32]));

        axi_read(32'h40, 32'h0, 2'b11);
        axi_read(32'h10, 32'hDEAD_BEEF, 2'b00);
        axi_read(32'h07, 32'h11BB_33DD, 2'b00);
        axi_read(32'h1C, 32'h7777_0007, 2'b00);

        // B backpressure: two writes to reg 0, the second stays buffered
        @(posedge clk); #1 bready = 1'b0;
        b_q.push_back(2'b00);
        send_aw_w(32'h0, 32'h0000_0001, 4'hF);
        b_q.push_back(2'b00);
        send_aw_w(32'h0, 32'h0000_0002, 4'hF);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("bp_awready", 256'(awready), 256'(0));
            chk("bp_wready", 256'(wready), 256'(0));
            chk("bp_bvalid", 256'(bvalid), 256'(1));
            chk("bp_bresp", 256'(bresp), 256'(0));
            chk("bp_reg0", 256'(slice(0)), 256'(1));
        end
        @(posedge clk); #1;
        bready = 1'b1; araddr = 32'h0; arvalid = 1'b1;
        r_q.push_back('{32'h0000_0001, 2'b00});
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk);
        chk("collide_reg0", 256'(slice(0)), 256'(2));
        chk("collide_pulse", 256'(wr_pulse_o), 256'(8'b0000_0001));
        chk("collide_bvalid", 256'(bvalid), 256'(1));
        @(negedge clk);
        chk("collide_pulse_end", 256'(wr_pulse_o), 256'(0));
        @(negedge clk);
        chk("bp_drained", 256'(bvalid), 256'(0));

        // R backpressure holds rdata/rresp and blocks AR
        @(posedge clk); #1;
        rready = 1'b0;
        r_q.push_back('{32'h0000_0280, 2'b00});
        araddr = 32'h0C; arvalid = 1'b1;
        @(posedge clk); #1 arvalid = 1'b0; araddr = 32'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rbp_rvalid", 256'(rvalid), 256'(1));
            chk("rbp_arready", 256'(arready), 256'(0));
            chk("rbp_rdata", 256'(rdata), 256'(32'h0000_0280));
        end
        @(posedge clk); #1 rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rbp_drained", 256'(rvalid), 256'(0));

        // Reset with an AW held in its buffer
        @(posedge clk); #1;
        awaddr = 32'h04; awvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0;
        #2 arst_n = 1'b0;
        #1;
        chk("mid_rst_bvalid", 256'(bvalid), 256'(0));
        chk("mid_rst_rvalid", 256'(rvalid), 256'(0));
        chk("mid_rst_awready", 256'(awready), 256'(1));
        chk("mid_rst_regs", 256'(regs_o), 256'(RST));
        @(posedge clk); #1 arst_n = 1'b1;
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1 wvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_pulse", 256'(wr_pulse_o), 256'(0));
            chk("post_rst_bvalid", 256'(bvalid), 256'(0));
            chk("post_rst_regs", 256'(regs_o), 256'(RST));
        end
        chk("post_rst_wready", 256'(wready), 256'(0));

        chk("b_queue_empty", 256'(b_q.size()), 256'(0));
        chk("r_queue_empty", 256'(r_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
